// File: rtl/gauge_link_pkg.sv
// Shared constants and helpers for the gauge telemetry receiver.
package gauge_link_pkg;

  // Parser states, kept as plain constants for compatibility with older tools.
  typedef logic [2:0] state_t;
  localparam state_t ST_HUNT = 3'd0;
  localparam state_t ST_LEN  = 3'd1;
  localparam state_t ST_HI   = 3'd2;
  localparam state_t ST_LO   = 3'd3;
  localparam state_t ST_CHK  = 3'd4;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  // Expected LEN byte: two payload bytes per channel.
  function automatic logic [7:0] len_byte(input int unsigned n_ch);
    return 8'(2 * n_ch);
  endfunction

  // Counter width able to hold the value max.
  function automatic int unsigned timer_width(input int unsigned max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

  // Channel index width, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gauge_sat_timer.sv
// Saturating up-counter; done is high while the count sits at MAX.
module gauge_sat_timer
  import gauge_link_pkg::*;
#(
  parameter int unsigned MAX = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int unsigned W = timer_width(MAX);
  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_q;

  // Count up to MAX and hold; clear has priority over enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != MAX_V)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign done = (cnt_q == MAX_V);

endmodule

// File: rtl/gauge_link_rx.sv
// Gauge telemetry receiver: parses SYNC/LEN/payload/CHK frames from the UART RX FIFO,
// commits all channels atomically on a good checksum, and tracks link health.
module gauge_link_rx
  import gauge_link_pkg::*;
#(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned VAL_W       = 12,
  parameter int unsigned STALE_CYC   = 5_000_000,
  parameter int unsigned BYTE_TO_CYC = 50_000,
  parameter logic [7:0]  SYNC        = SYNC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rx_empty,
  input  logic [7:0]            r_data,
  output logic                  rd_uart,
  output logic [N_CH*VAL_W-1:0] ch_val,
  output logic                  frame_tick,
  output logic                  err_len,
  output logic                  err_chk,
  output logic                  err_to,
  output logic                  stale,
  output logic [15:0]           frame_cnt,
  output logic [7:0]            err_cnt
);

  localparam int unsigned      IDX_W    = idx_width(N_CH);
  localparam logic [7:0]       LEN_V    = len_byte(N_CH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_CH - 1);

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [7:0]            acc_q, acc_d;
  logic [VAL_W-9:0]      hi_q, hi_d;
  logic [N_CH*VAL_W-1:0] shadow_q, shadow_d;
  logic                  no_frame_q;

  logic accept;
  logic commit, len_bad, chk_bad, timeout, any_err;
  logic byte_clr, byte_done, stale_done;

  // No backpressure: every byte at the FIFO head is popped.
  assign rd_uart  = !rx_empty;
  assign accept   = !rx_empty;
  assign byte_clr = accept || (state_q == ST_HUNT);
  assign any_err  = len_bad || chk_bad || timeout;
  // Before the first good frame the link counts as stale regardless of the timer.
  assign stale    = no_frame_q || stale_done;

  gauge_sat_timer #(
    .MAX(BYTE_TO_CYC)
  ) u_byte_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (byte_clr),
    .en     (1'b1),
    .done   (byte_done)
  );

  gauge_sat_timer #(
    .MAX(STALE_CYC)
  ) u_stale_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (commit),
    .en     (1'b1),
    .done   (stale_done)
  );

  // Frame parser next-state; an arriving byte always beats a coincident timeout.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    shadow_d = shadow_q;
    commit   = 1'b0;
    len_bad  = 1'b0;
    chk_bad  = 1'b0;
    timeout  = 1'b0;
    if (accept) begin
      case (state_q)
        ST_HUNT: begin
          if (r_data == SYNC) state_d = ST_LEN;
        end
        ST_LEN: begin
          if (r_data == LEN_V) begin
            acc_d   = r_data;
            idx_d   = '0;
            state_d = ST_HI;
          end else begin
            len_bad = 1'b1;
            state_d = ST_HUNT;
          end
        end
        ST_HI: begin
          hi_d    = r_data[VAL_W-9:0];
          acc_d   = acc_q + r_data;
          state_d = ST_LO;
        end
        ST_LO: begin
          shadow_d[idx_q*VAL_W +: VAL_W] = {hi_q, r_data};
          acc_d = acc_q + r_data;
          if (idx_q == IDX_LAST) begin
            state_d = ST_CHK;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_HI;
          end
        end
        ST_CHK: begin
          if (r_data == acc_q) commit = 1'b1;
          else                 chk_bad = 1'b1;
          state_d = ST_HUNT;
        end
        default: state_d = ST_HUNT;
      endcase
    end else if (byte_done && (state_q != ST_HUNT)) begin
      timeout = 1'b1;
      state_d = ST_HUNT;
    end
  end

  // Parser state, checksum accumulator and shadow buffer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_HUNT;
      idx_q    <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      shadow_q <= shadow_d;
    end
  end

  // Committed values and one-cycle event pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ch_val     <= '0;
      frame_tick <= 1'b0;
      err_len    <= 1'b0;
      err_chk    <= 1'b0;
      err_to     <= 1'b0;
    end else begin
      if (commit) ch_val <= shadow_q;
      frame_tick <= commit;
      err_len    <= len_bad;
      err_chk    <= chk_bad;
      err_to     <= timeout;
    end
  end

  // Saturating status counters and the never-received flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt  <= '0;
      err_cnt    <= '0;
      no_frame_q <= 1'b1;
    end else begin
      if (commit) begin
        no_frame_q <= 1'b0;
        if (frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 1'b1;
      end
      if (any_err && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: doc/gauge_link_rx.md
Name: gauge_link_rx

Overview:
Parametrised serial telemetry receiver that replaces soft-core register polling for gauge values. It drains bytes from the UART RX FIFO and parses fixed-format frames carrying N_CH channel values. Each value is VAL_W bits wide. On a good checksum it atomically commits all channels to the front panel controller. It also flags stale data (link loss) and mid-frame stalls, and maintains saturating frame/error counters for status reporting.

Parameters:
N_CH, 4, number of channels per frame (1..16); channel 0 is first on the wire
VAL_W, 12, bits per channel value (9..16); sent as high byte then low byte
STALE_CYC, 5_000_000, cycles without a good frame before stale asserts (100 ms at 50 MHz)
BYTE_TO_CYC, 50_000, max cycles between bytes inside a frame before abort (1 ms)
SYNC, 8'hA5, frame start byte

Ports:
clk  in  1  system clock (50 MHz)
reset_n  in  1  asynchronous active-low reset
rx_empty  in  1  UART RX FIFO empty
r_data  in  8  UART RX FIFO head byte, valid while rx_empty=0
rd_uart  out  1  FIFO pop; byte on r_data consumed in the same cycle
ch_val  out  N_CH*VAL_W  committed values; channel i at [i*VAL_W +: VAL_W]
frame_tick  out  1  one-cycle pulse on each committed frame
err_len  out  1  one-cycle pulse, LEN byte mismatch
err_chk  out  1  one-cycle pulse, checksum mismatch
err_to  out  1  one-cycle pulse, inter-byte timeout abort
stale  out  1  no good frame within STALE_CYC
frame_cnt  out  16  good frames, saturating at 16'hFFFF
err_cnt  out  8  sum of all error events, saturating at 8'hFF

Behaviour:
- Wire format: SYNC, LEN, then for each channel HI and LO, then CHK. LEN must equal 2*N_CH. Value = {HI[VAL_W-9:0], LO}; unused HI bits are ignored. CHK = (LEN + all payload bytes) mod 256.
- rd_uart = !rx_empty (combinational). At most one byte is accepted per cycle. No backpressure; every byte is consumed.
- FSM states: HUNT, LEN, HI, LO, CHK. A channel index idx counts 0..N_CH-1.
- HUNT: bytes other than SYNC are discarded silently, with no error. SYNC moves to LEN.
- LEN: if the byte equals 2*N_CH, clear the checksum accumulator, load it with LEN, set idx=0 and go to HI. Otherwise pulse err_len and go to HUNT.
- HI: latch into the shadow buffer and go to LO.
- LO: write shadow[idx] and add to the accumulator. If idx==N_CH-1 go to CHK; else idx++ and go to HI.
- CHK: on match, commit shadow to ch_val, pulse frame_tick, increment frame_cnt and clear the stale timer. On mismatch, pulse err_chk and leave ch_val unchanged. Both cases go to HUNT.
- Latency: ch_val and frame_tick update at the clock edge that accepts the CHK byte, so they are visible the following cycle. All channels change together; there is never a partial update.
- Byte timer: runs in every state except HUNT and reloads on each accepted byte. On reaching BYTE_TO_CYC it pulses err_to and goes to HUNT. If a byte arrives in the same cycle as expiry, the byte is processed and the timeout is suppressed.
- Stale timer: counts up and saturates at STALE_CYC; stale=1 while saturated. A good frame clears it, and stale=0 from the next cycle. A good frame in the same cycle as saturation wins.
- err_cnt increments on each err_len, err_chk or err_to pulse. At most one error can occur per cycle.
- Reset values: ch_val=0, rd_uart follows rx_empty, all pulses=0, stale=1, frame_cnt=0, err_cnt=0, FSM=HUNT, timers=0.
- Reset mid-frame discards the shadow buffer. No commit and no error pulse are generated.

Decomposition:
- Package gauge_link_pkg holds the FSM state enum, the default SYNC value, and helper functions for the LEN value and timer widths ($clog2 of the cycle counts).
- Sub-module gauge_sat_timer (parameter MAX; inputs clr and en; output done) provides a saturating counter. It is instantiated twice: once for the stale timer and once for the byte timer.

Test Plan:
- Good frame (N_CH=4, VAL_W=12): bytes A5 08 01 23 0F FF 00 00 08 00 42 -> ch0=0x123, ch1=0xFFF, ch2=0x000, ch3=0x800. frame_tick pulses 1 cycle after CHK; frame_cnt=1; stale falls.
- Same frame with CHK=43 -> err_chk pulses once, err_cnt=1, ch_val stays at its previous values. A following good frame commits normally.
- Garbage 00 FF 5A before A5, plus a frame with LEN=06 -> garbage produces no error; LEN=06 gives err_len. The next A5 08 ... frame parses correctly.
- Stall 60_000 cycles after the 3rd payload byte -> err_to fires at exactly BYTE_TO_CYC after the last byte, FSM returns to HUNT, ch_val is unchanged. Also check that a byte arriving in the expiry cycle suppresses the timeout.
- No frames for STALE_CYC cycles after a good frame -> stale rises exactly on saturation. A good frame completing in the saturation cycle keeps stale=0.
- Assert reset_n low mid-payload, then release and send a full good frame -> all outputs return to reset values, and the new frame commits with no error pulses.
